mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage between the execute stage (ES) and the write-back stage (WS).
//  It receives the ES payload and waits for the data-SRAM response when ES issued a request.
//  It extracts and extends load data, then hands one result per instruction to WS.
//  It forwards its state to the decode stage (DS) for bypass and load-use stall.
//  On a WS exception/ertn flush it drops in-flight work and discards stale SRAM responses.
// PARAMETERS
//  MAX_OUTSTANDING  2  max data_ok responses to discard after a flush (counter saturates here)
// PORTS
//  clk              in   1   clock
//  reset            in   1   asynchronous, active-high reset
//  ms_allowin       out  1   MS can accept a new ES instruction this cycle
//  es_to_ms_valid   in   1   ES payload valid
//  es_pc            in   32  instruction PC
//  es_dest          in   5   destination GR
//  es_gr_we         in   1   instruction writes GR
//  es_mem_req       in   1   ES issued a data-SRAM request (accepted) for this instruction
//  es_res_from_mem  in   1   result is load data
//  es_load_op       in   3   0 ld.w, 1 ld.b, 2 ld.h, 3 ld.bu, 4 ld.hu
//  es_alu_result    in   32  ALU result / memory address
//  es_excp          in   1   exception already detected upstream
//  es_excp_num      in   16  one-hot exception vector, WS priority encoding
//  data_sram_data_ok in  1   read/write response valid
//  data_sram_rdata  in   32  read data, valid with data_ok
//  ws_allowin       in   1   WS can accept
//  wb_flush         in   1   excp_flush | ertn_flush from WS
//  ms_to_ws_valid   out  1   payload to WS valid
//  ms_pc            out  32  registered es_pc
//  ms_dest, ms_gr_we  out 5,1  registered
//  ms_final_result  out  32  load data (extended) or ALU result
//  ms_excp, ms_excp_num  out 1,16  registered exception info
//  ms_err_addr      out  32  registered es_alu_result (BADV source)
//  ms_forward       out  40  {ms_valid, ms_gr_we, ms_dest[4:0], ms_data_pending, ms_final_result}
//  ms_ex            out  1   ms_valid & ms_excp; ES uses it to suppress new stores
// BEHAVIOUR
//  Reset: ms_valid=0, state=IDLE, discard_cnt=0; all outputs 0 except ms_allowin=1. Payload regs are not reset.
//  States:
//   IDLE: no instruction.
//   WAIT: valid, es_mem_req=1, data_ok not yet seen.
//   HOLD: valid, result ready, waiting for ws_allowin.
//  ms_ready_go = ms_excp | (state==HOLD) | (state==WAIT & data_ok & discard_cnt==0)
//  ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
//  ms_to_ws_valid = ms_valid & ms_ready_go & !wb_flush.
//  Accept (es_to_ms_valid & ms_allowin & !wb_flush):
//   - latch the payload.
//   - next state = WAIT if es_mem_req & !es_excp, else HOLD.
//  WAIT, data_ok with discard_cnt==0:
//   - result = load data.
//   - if !ws_allowin, capture rdata into a buffer and go to HOLD.
//   - else pass through in the same cycle (0 added latency).
//  Load extract, byte select addr[1:0], halfword select addr[1]:
//   - b/h sign-extend; bu/hu zero-extend; w passes through.
//   - Non-load result = es_alu_result.
//  Flush (wb_flush=1):
//   - ms_valid<=0 next cycle; state->IDLE.
//   - If state was WAIT without data_ok this cycle, discard_cnt+=1.
//   - An incoming es_to_ms_valid in the same cycle is not accepted.
//  Discard: while discard_cnt>0, each data_ok decrements it and is not used.
//   - If data_ok arrives while a new instruction is in WAIT, it is dropped first.
//   - The new instruction waits for the next data_ok.
//   - discard_cnt saturates at MAX_OUTSTANDING.
//  Accept while leaving: MS advances and accepts in the same cycle (back-to-back throughput 1/cycle).
//  ms_data_pending = ms_valid & es_res_from_mem latched & state==WAIT; DS must stall on it.
//  ms_excp loads skip the SRAM wait even if es_mem_req=1; a stale response is not counted.
//  ES must not raise es_mem_req when it has an exception.
// TESTING
//  1. ld.b, addr=0x1003, rdata=0x80FF_0000, data_ok 2 cycles after accept, ws_allowin=1:
//     -> ms_final_result=0xFFFF_FF80, ms_to_ws_valid for 1 cycle.
//  2. ld.hu, addr[1]=1, rdata=0x8001_1234 -> 0x0000_8001; ld.h, addr[1]=0 -> 0x0000_1234.
//  3. ALU op (es_mem_req=0) back-to-back with ws_allowin=1 for 4 instructions:
//     -> ms_to_ws_valid held 4 consecutive cycles, ms_allowin=1 throughout.
//  4. Load in WAIT, wb_flush pulse, next load accepted, then two data_ok (0x11, 0x22):
//     -> 0x11 discarded; second load result 0x22; discard_cnt returns to 0.
//  5. data_ok with ws_allowin=0 for 3 cycles:
//     -> state HOLD, data held, ms_allowin=0; released the cycle ws_allowin=1.
//  6. Assert reset mid-WAIT:
//     -> ms_to_ws_valid=0 and ms_forward[39]=0 immediately (async); discard_cnt=0.

Source files
------------

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Bundle of the ES -> MS -> WS handshake, data-SRAM response
//                and DS forwarding signals around the memory-access stage.
//                The master modport is the memory stage itself; the slave
//                modport is the surrounding pipeline / SRAM environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
   // ES -> MS
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [31:0] es_pc;
   logic [4:0]  es_dest;
   logic        es_gr_we;
   logic        es_mem_req;
   logic        es_res_from_mem;
   logic [2:0]  es_load_op;
   logic [31:0] es_alu_result;
   logic        es_excp;
   logic [15:0] es_excp_num;
   // data SRAM response
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   // WS control
   logic        ws_allowin;
   logic        wb_flush;
   // MS -> WS / DS / ES
   logic        ms_to_ws_valid;
   logic [31:0] ms_pc;
   logic [4:0]  ms_dest;
   logic        ms_gr_we;
   logic [31:0] ms_final_result;
   logic        ms_excp;
   logic [15:0] ms_excp_num;
   logic [31:0] ms_err_addr;
   logic [39:0] ms_forward;
   logic        ms_ex;

   modport master (
      output ms_allowin,
      input  es_to_ms_valid, es_pc, es_dest, es_gr_we, es_mem_req,
             es_res_from_mem, es_load_op, es_alu_result, es_excp, es_excp_num,
      input  data_sram_data_ok, data_sram_rdata,
      input  ws_allowin, wb_flush,
      output ms_to_ws_valid, ms_pc, ms_dest, ms_gr_we, ms_final_result,
             ms_excp, ms_excp_num, ms_err_addr, ms_forward, ms_ex
   );

   modport slave (
      input  ms_allowin,
      output es_to_ms_valid, es_pc, es_dest, es_gr_we, es_mem_req,
             es_res_from_mem, es_load_op, es_alu_result, es_excp, es_excp_num,
      output data_sram_data_ok, data_sram_rdata,
      output ws_allowin, wb_flush,
      input  ms_to_ws_valid, ms_pc, ms_dest, ms_gr_we, ms_final_result,
             ms_excp, ms_excp_num, ms_err_addr, ms_forward, ms_ex
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory-access pipeline stage. Holds one instruction from ES,
//                waits for its data-SRAM response, extracts/extends load data
//                and hands one result per instruction to WS. Responses that
//                belong to flushed instructions are counted and discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   mem_stage_if.master bus
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      r_state, w_state_next;
   logic        r_valid, w_valid_next;
   logic [CW-1:0] r_discard_cnt, w_discard_next;

   // payload (not reset; every output is qualified by r_valid)
   logic [31:0] r_pc;
   logic [4:0]  r_dest;
   logic        r_gr_we;
   logic        r_res_from_mem;
   logic [2:0]  r_load_op;
   logic [31:0] r_alu_result;
   logic        r_excp;
   logic [15:0] r_excp_num;
   logic [31:0] r_rdata_buf;

   logic        w_ok_used;
   logic        w_ok_drop;
   logic        w_ready_go;
   logic        w_allowin;
   logic        w_accept;
   logic        w_leave;
   logic        w_flush_lost;
   logic [31:0] w_load_src;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [31:0] w_final_result;
   logic        w_data_pending;

   // A response is ours only when no stale response is still owed.
   assign w_ok_used  = bus.data_sram_data_ok & (r_discard_cnt == '0);
   assign w_ok_drop  = bus.data_sram_data_ok & (r_discard_cnt != '0);
   assign w_ready_go = r_excp | (r_state == S_HOLD) | ((r_state == S_WAIT) & w_ok_used);
   assign w_allowin  = ~r_valid | (w_ready_go & bus.ws_allowin);
   assign w_accept   = bus.es_to_ms_valid & w_allowin & ~bus.wb_flush;
   assign w_leave    = r_valid & w_ready_go & bus.ws_allowin;
   // The flushed instruction's response is still on its way and must be eaten.
   assign w_flush_lost = bus.wb_flush & r_valid & (r_state == S_WAIT) & ~w_ok_used;

   // State register, valid flag and discard counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_valid       <= 1'b0;
         r_discard_cnt <= '0;
      end else begin
         r_state       <= w_state_next;
         r_valid       <= w_valid_next;
         r_discard_cnt <= w_discard_next;
      end
   end

   // Next-state: flush wins, then accept (also covers accept-while-leaving)
   always_comb begin
      w_state_next = r_state;
      w_valid_next = r_valid;
      if (bus.wb_flush) begin
         w_valid_next = 1'b0;
         w_state_next = S_IDLE;
      end else if (w_accept) begin
         w_valid_next = 1'b1;
         w_state_next = (bus.es_mem_req & ~bus.es_excp) ? S_WAIT : S_HOLD;
      end else if (w_leave) begin
         w_valid_next = 1'b0;
         w_state_next = S_IDLE;
      end else if (r_valid && (r_state == S_WAIT) && w_ok_used) begin
         w_state_next = S_HOLD;
      end
   end

   // Discard counter: consume one stale response, add one per lost request, saturate
   always_comb begin
      w_discard_next = r_discard_cnt;
      if (w_ok_drop) begin
         w_discard_next = r_discard_cnt - CW'(1);
      end
      if (w_flush_lost && (w_discard_next != CW'(MAX_OUTSTANDING))) begin
         w_discard_next = w_discard_next + CW'(1);
      end
   end

   // Payload capture on accept, and read-data capture when WS stalls a response
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_pc           <= bus.es_pc;
         r_dest         <= bus.es_dest;
         r_gr_we        <= bus.es_gr_we;
         r_res_from_mem <= bus.es_res_from_mem;
         r_load_op      <= bus.es_load_op;
         r_alu_result   <= bus.es_alu_result;
         r_excp         <= bus.es_excp;
         r_excp_num     <= bus.es_excp_num;
      end
      if ((r_state == S_WAIT) && w_ok_used) begin
         r_rdata_buf <= bus.data_sram_rdata;
      end
   end

   // Load data extraction: byte by addr[1:0], halfword by addr[1]
   always_comb begin
      w_load_src = (r_state == S_HOLD) ? r_rdata_buf : bus.data_sram_rdata;
      case (r_alu_result[1:0])
         2'd0:    w_byte = w_load_src[7:0];
         2'd1:    w_byte = w_load_src[15:8];
         2'd2:    w_byte = w_load_src[23:16];
         default: w_byte = w_load_src[31:24];
      endcase
      w_half = r_alu_result[1] ? w_load_src[31:16] : w_load_src[15:0];
      case (r_load_op)
         3'd1:    w_load_data = {{24{w_byte[7]}}, w_byte};
         3'd2:    w_load_data = {{16{w_half[15]}}, w_half};
         3'd3:    w_load_data = {24'h0, w_byte};
         3'd4:    w_load_data = {16'h0, w_half};
         default: w_load_data = w_load_src;
      endcase
      // Excepting loads never received data, so they report the address.
      w_final_result = (r_res_from_mem & ~r_excp) ? w_load_data : r_alu_result;
   end

   assign w_data_pending = r_valid & r_res_from_mem & (r_state == S_WAIT);

   assign bus.ms_allowin      = w_allowin;
   assign bus.ms_to_ws_valid  = r_valid & w_ready_go & ~bus.wb_flush;
   assign bus.ms_pc           = r_valid ? r_pc : 32'h0;
   assign bus.ms_dest         = r_valid ? r_dest : 5'h0;
   assign bus.ms_gr_we        = r_valid & r_gr_we;
   assign bus.ms_final_result = r_valid ? w_final_result : 32'h0;
   assign bus.ms_excp         = r_valid & r_excp;
   assign bus.ms_excp_num     = r_valid ? r_excp_num : 16'h0;
   assign bus.ms_err_addr     = r_valid ? r_alu_result : 32'h0;
   assign bus.ms_ex           = r_valid & r_excp;
   assign bus.ms_forward      = {r_valid, r_valid & r_gr_we, (r_valid ? r_dest : 5'h0),
                                 w_data_pending, (r_valid ? w_final_result : 32'h0)};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Randomised scoreboard bench for mem_stage. Each accepted
//                instruction carries its own SRAM read data and the expected
//                result; an in-order SRAM responder returns the data, and a
//                monitor compares every handshake against the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

   logic clk = 1'b0;
   logic reset = 1'b1;

   mem_stage_if bus ();

   mem_stage #(.MAX_OUTSTANDING(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic [4:0]  dest;
      logic        gr_we;
      logic        req;
      logic        rfm;
      logic [2:0]  op;
      logic [31:0] alu;
      logic        excp;
      logic [15:0] en;
      logic [31:0] rdata;
      int          delay;
      logic [31:0] exp_res;
      bit          seen;
   } ins_t;

   typedef struct {
      int          id;
      logic [31:0] rdata;
      int          ready;
   } rsp_t;

   ins_t sb_q[$];
   rsp_t rsp_q[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int next_id  = 0;
   int cur_id   = -1;
   int outs     = 0;

   bit   rand_env  = 1'b0;
   int   flush_pct = 0;
   logic d_ws      = 1'b1;
   logic d_flush   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Result of an instruction from the architectural load rules
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic rfm,
                                              input logic excp, input logic [31:0] addr,
                                              input logic [31:0] rd);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      if (!rfm || excp) return addr;
      sh = rd >> (8 * addr[1:0]);
      b  = sh[7:0];
      h  = addr[1] ? rd[31:16] : rd[15:0];
      case (op)
         3'd1:    return {{24{b[7]}}, b};
         3'd2:    return {{16{h[15]}}, h};
         3'd3:    return {24'h0, b};
         3'd4:    return {16'h0, h};
         default: return rd;
      endcase
   endfunction

   function automatic ins_t mk_ins(input logic [2:0] op, input logic rfm, input logic req,
                                   input logic [31:0] addr, input logic [31:0] rd,
                                   input int delay, input logic [31:0] exp_res);
      ins_t t;
      t.id = 0; t.pc = $urandom; t.dest = 5'($urandom); t.gr_we = 1'b1;
      t.req = req; t.rfm = rfm; t.op = op; t.alu = addr; t.excp = 1'b0;
      t.en = 16'h0; t.rdata = rd; t.delay = delay; t.exp_res = exp_res; t.seen = 1'b0;
      return t;
   endfunction

   function automatic ins_t rand_ins();
      ins_t t;
      int   k;
      k = $urandom_range(0, 9);
      t.id = 0; t.pc = $urandom; t.dest = 5'($urandom); t.gr_we = 1'($urandom);
      t.alu = $urandom; t.rdata = $urandom; t.delay = $urandom_range(1, 4);
      t.rfm = (k < 4); t.req = (k < 6); t.op = (k < 4) ? 3'($urandom_range(0, 4)) : 3'd0;
      t.excp = ($urandom_range(0, 9) == 0);
      t.en = t.excp ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
      if (t.excp) t.req = 1'b0;
      t.exp_res = ref_result(t.op, t.rfm, t.excp, t.alu, t.rdata);
      t.seen = 1'b0;
      return t;
   endfunction

   // Present one instruction until accepted; record it on acceptance.
   task automatic send(input ins_t t);
      int   n;
      bit   acc;
      rsp_t r;
      n = 0;
      acc = 1'b0;
      bus.es_to_ms_valid  = 1'b1;
      bus.es_pc           = t.pc;
      bus.es_dest         = t.dest;
      bus.es_gr_we        = t.gr_we;
      bus.es_mem_req      = t.req;
      bus.es_res_from_mem = t.rfm;
      bus.es_load_op      = t.op;
      bus.es_alu_result   = t.alu;
      bus.es_excp         = t.excp;
      bus.es_excp_num     = t.en;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = bus.ms_allowin && !bus.wb_flush;
         @(posedge clk);
         #1;
         n++;
      end
      bus.es_to_ms_valid = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=not_accepted required=accepted");
      end else begin
         t.id = next_id++;
         t.seen = 1'b0;
         sb_q.push_back(t);
         if (t.req) begin
            r.id = t.id; r.rdata = t.rdata; r.ready = cyc + t.delay;
            rsp_q.push_back(r);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // In-order SRAM responder
   initial begin
      rsp_t r;
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         bus.data_sram_data_ok = 1'b0;
         cur_id = -1;
         if (!reset && rsp_q.size() > 0 && rsp_q[0].ready <= cyc) begin
            r = rsp_q.pop_front();
            bus.data_sram_data_ok = 1'b1;
            bus.data_sram_rdata   = r.rdata;
            cur_id = r.id;
         end
      end
   end

   // WS side: random back-pressure and flushes, or directed values
   initial begin
      bus.ws_allowin = 1'b1;
      bus.wb_flush   = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rand_env) begin
            bus.ws_allowin = ($urandom_range(0, 3) != 0);
            bus.wb_flush   = ($urandom_range(0, 99) < flush_pct) && (rsp_q.size() <= 1);
         end else begin
            bus.ws_allowin = d_ws;
            bus.wb_flush   = d_flush;
         end
      end
   end

   // Monitor: compare DUT against the instruction at the head of the scoreboard
   initial begin
      ins_t f;
      bit   ev, ok_now, rdy;
      forever begin
         @(negedge clk);
         if (!reset) begin
            ev = (sb_q.size() > 0);
            if (ev) f = sb_q[0];
            ok_now = ev && f.req && bus.data_sram_data_ok && (cur_id == f.id);
            rdy = ev && (f.excp || !f.req || f.seen || ok_now);
            chk("fwd_valid", 64'(bus.ms_forward[39]), 64'(ev));
            chk("to_ws_valid", 64'(bus.ms_to_ws_valid), 64'(rdy && !bus.wb_flush));
            chk("allowin", 64'(bus.ms_allowin), 64'(!ev || (rdy && bus.ws_allowin)));
            if (ev) begin
               chk("ms_ex", 64'(bus.ms_ex), 64'(f.excp));
               chk("pending", 64'(bus.ms_forward[32]), 64'(f.req && f.rfm && !f.seen));
               chk("fwd_dest", 64'(bus.ms_forward[37:33]), 64'(f.dest));
               chk("fwd_we", 64'(bus.ms_forward[38]), 64'(f.gr_we));
            end
            if (rdy && !bus.wb_flush && bus.ws_allowin) begin
               chk("pc", 64'(bus.ms_pc), 64'(f.pc));
               chk("dest", 64'(bus.ms_dest), 64'(f.dest));
               chk("gr_we", 64'(bus.ms_gr_we), 64'(f.gr_we));
               chk("result", 64'(bus.ms_final_result), 64'(f.exp_res));
               chk("fwd_result", 64'(bus.ms_forward[31:0]), 64'(f.exp_res));
               chk("excp", 64'(bus.ms_excp), 64'(f.excp));
               chk("excp_num", 64'(bus.ms_excp_num), 64'(f.en));
               chk("err_addr", 64'(bus.ms_err_addr), 64'(f.alu));
               void'(sb_q.pop_front());
               outs++;
            end else if (ev && bus.wb_flush) begin
               void'(sb_q.pop_front());
            end else if (ok_now) begin
               sb_q[0].seen = 1'b1;
            end
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() > 0 || rsp_q.size() > 0) && n < 200) begin
         idle(1);
         n++;
      end
      chk("drain_sb", 64'(sb_q.size()), 64'd0);
      chk("drain_rsp", 64'(rsp_q.size()), 64'd0);
   endtask

   initial begin
      bus.es_to_ms_valid = 1'b0; bus.es_pc = 32'h0; bus.es_dest = 5'h0; bus.es_gr_we = 1'b0;
      bus.es_mem_req = 1'b0; bus.es_res_from_mem = 1'b0; bus.es_load_op = 3'd0;
      bus.es_alu_result = 32'h0; bus.es_excp = 1'b0; bus.es_excp_num = 16'h0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_allowin", 64'(bus.ms_allowin), 64'd1);
      chk("rst_to_ws", 64'(bus.ms_to_ws_valid), 64'd0);
      chk("rst_forward", 64'(bus.ms_forward), 64'd0);
      chk("rst_ex", 64'(bus.ms_ex), 64'd0);
      chk("rst_pc", 64'(bus.ms_pc), 64'd0);
      chk("rst_result", 64'(bus.ms_final_result), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      idle(1);

      // ld.b from top byte, sign-extended
      send(mk_ins(3'd1, 1'b1, 1'b1, 32'h0000_1003, 32'h80FF_0000, 2, 32'hFFFF_FF80));
      idle(4);
      // ld.hu upper half, ld.h lower half
      send(mk_ins(3'd4, 1'b1, 1'b1, 32'h0000_2002, 32'h8001_1234, 1, 32'h0000_8001));
      send(mk_ins(3'd2, 1'b1, 1'b1, 32'h0000_2000, 32'h8001_1234, 1, 32'h0000_1234));
      idle(4);
      // four ALU ops back-to-back
      for (int i = 0; i < 4; i++) begin
         ins_t t;
         t = mk_ins(3'd0, 1'b0, 1'b0, $urandom, 32'h0, 1, 32'h0);
         t.exp_res = t.alu;
         send(t);
      end
      idle(3);
      // WS stalls while the response arrives
      d_ws = 1'b0;
      send(mk_ins(3'd0, 1'b1, 1'b1, 32'h0000_3000, 32'hCAFE_BABE, 1, 32'hCAFE_BABE));
      idle(4);
      d_ws = 1'b1;
      idle(3);
      // flush while waiting; stale 0x11 must be dropped
      send(mk_ins(3'd0, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_0011, 5, 32'h0000_0011));
      d_flush = 1'b1;
      idle(1);
      d_flush = 1'b0;
      idle(1);
      send(mk_ins(3'd0, 1'b1, 1'b1, 32'h0000_4004, 32'h0000_0022, 1, 32'h0000_0022));
      drain();

      // randomised traffic with back-pressure and flushes
      flush_pct = 6;
      rand_env  = 1'b1;
      repeat (300) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else send(rand_ins());
      end
      rand_env = 1'b0;
      d_ws = 1'b1;
      d_flush = 1'b0;
      drain();

      // asynchronous reset while waiting for data
      send(mk_ins(3'd0, 1'b1, 1'b1, 32'h0000_5000, 32'h1234_5678, 20, 32'h1234_5678));
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("async_to_ws", 64'(bus.ms_to_ws_valid), 64'd0);
      chk("async_fwd_valid", 64'(bus.ms_forward[39]), 64'd0);
      chk("async_allowin", 64'(bus.ms_allowin), 64'd1);
      sb_q.delete();
      rsp_q.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      idle(1);
      // a fresh load must use the very first response after reset
      send(mk_ins(3'd0, 1'b1, 1'b1, 32'h0000_6000, 32'h0BAD_F00D, 1, 32'h0BAD_F00D));
      drain();
      chk("outputs_seen", 64'(outs > 10), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
